// File: rtl/sm4_key_latch.sv
// SM4 session key latch: samples a random candidate from the generator,
// rejects weak or repeated values with bounded retries, holds the accepted
// key and offers it downstream as four 32-bit words, most significant first.
module sm4_key_latch #(
    parameter int MAX_RETRY = 3,
    parameter bit REJ_ONES  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] rdm_num,
    input  logic         key_req,
    input  logic         err_clr,
    input  logic         word_rdy,
    output logic         busy,
    output logic [127:0] key,
    output logic         key_vld,
    output logic [31:0]  word_out,
    output logic         word_vld,
    output logic         word_last,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        CHECK  = 3'd2,
        SEND   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [3:0] MaxRetryW = 4'(MAX_RETRY);

    state_t       state_q, state_d;
    logic [127:0] cand_q, cand_d;
    logic [127:0] key_q, key_d;
    logic [127:0] prev_key_q, prev_key_d;
    logic [3:0]   retry_cnt_q, retry_cnt_d;
    logic [1:0]   word_idx_q, word_idx_d;
    logic         key_vld_q, key_vld_d;
    logic         word_vld_q, word_vld_d;
    logic         word_last_q, word_last_d;
    logic [31:0]  word_out_q, word_out_d;
    logic         busy_q, busy_d;
    logic         err_q, err_d;

    logic         candReject;
    logic [1:0]   nextIdx;

    // Picks one 32-bit word of the key; index 0 is the most significant word.
    function automatic logic [31:0] wordSel(input logic [127:0] k, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

    // Next-state and next-output logic; every output is registered so that
    // reset clears the visible interface asynchronously.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        key_d       = key_q;
        prev_key_d  = prev_key_q;
        retry_cnt_d = retry_cnt_q;
        word_idx_d  = word_idx_q;
        key_vld_d   = key_vld_q;
        word_vld_d  = word_vld_q;
        word_last_d = word_last_q;
        word_out_d  = word_out_q;
        busy_d      = busy_q;
        err_d       = err_q;

        candReject = (cand_q == '0) || (cand_q == prev_key_q) ||
                     (REJ_ONES && (cand_q == '1));
        nextIdx    = word_idx_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (key_req) begin
                    state_d     = SAMPLE;
                    retry_cnt_d = 4'd0;
                    key_vld_d   = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            SAMPLE: begin
                cand_d  = rdm_num;
                state_d = CHECK;
            end
            CHECK: begin
                if (candReject) begin
                    if ((retry_cnt_q + 4'd1) == MaxRetryW) begin
                        state_d   = ERR;
                        err_d     = 1'b1;
                        busy_d    = 1'b0;
                        key_vld_d = 1'b0;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        state_d     = SAMPLE;
                    end
                end else begin
                    key_d       = cand_q;
                    prev_key_d  = cand_q;
                    key_vld_d   = 1'b1;
                    word_idx_d  = 2'd0;
                    word_vld_d  = 1'b1;
                    word_last_d = 1'b0;
                    word_out_d  = cand_q[127:96];
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (word_vld_q && word_rdy) begin
                    if (word_idx_q == 2'd3) begin
                        state_d     = IDLE;
                        word_vld_d  = 1'b0;
                        word_last_d = 1'b0;
                        word_out_d  = '0;
                        busy_d      = 1'b0;
                    end else begin
                        word_idx_d  = nextIdx;
                        word_out_d  = wordSel(key_q, nextIdx);
                        word_last_d = (nextIdx == 2'd3);
                    end
                end
            end
            ERR: begin
                if (err_clr) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, forced to their idle values by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            key_q       <= '0;
            prev_key_q  <= '0;
            retry_cnt_q <= 4'd0;
            word_idx_q  <= 2'd0;
            key_vld_q   <= 1'b0;
            word_vld_q  <= 1'b0;
            word_last_q <= 1'b0;
            word_out_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            prev_key_q  <= prev_key_d;
            retry_cnt_q <= retry_cnt_d;
            word_idx_q  <= word_idx_d;
            key_vld_q   <= key_vld_d;
            word_vld_q  <= word_vld_d;
            word_last_q <= word_last_d;
            word_out_q  <= word_out_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign key       = key_q;
    assign key_vld   = key_vld_q;
    assign word_out  = word_out_q;
    assign word_vld  = word_vld_q;
    assign word_last = word_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sm4_key_latch.sv
// Self-checking bench for sm4_key_latch: scenario tasks drive key requests,
// push the expected key words into a scoreboard and pop them as the DUT
// hands each word over.
module tb_sm4_key_latch;

    logic         clk;
    logic         rst;
    logic [127:0] rdm_num;
    logic         key_req;
    logic         err_clr;
    logic         word_rdy;
    logic         busy;
    logic [127:0] key;
    logic         key_vld;
    logic [31:0]  word_out;
    logic         word_vld;
    logic         word_last;
    logic         err;

    int passCount  = 0;
    int checkCount = 0;

    logic [31:0] expWordQ[$];
    logic        expLastQ[$];

    logic [127:0] keyOne;
    logic [127:0] keyA5;
    logic [127:0] keyThree;
    logic [127:0] keyFour;
    logic [127:0] keySix;

    sm4_key_latch #(
        .MAX_RETRY(3),
        .REJ_ONES (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdm_num  (rdm_num),
        .key_req  (key_req),
        .err_clr  (err_clr),
        .word_rdy (word_rdy),
        .busy     (busy),
        .key      (key),
        .key_vld  (key_vld),
        .word_out (word_out),
        .word_vld (word_vld),
        .word_last(word_last),
        .err      (err)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_key(input logic [127:0] k);
        expWordQ.push_back(k[127:96]);
        expWordQ.push_back(k[95:64]);
        expWordQ.push_back(k[63:32]);
        expWordQ.push_back(k[31:0]);
        expLastQ.push_back(1'b0);
        expLastQ.push_back(1'b0);
        expLastQ.push_back(1'b0);
        expLastQ.push_back(1'b1);
    endtask

    task automatic pulse_req();
        key_req = 1'b1;
        tick();
        key_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        key_req  = 1'b0;
        err_clr  = 1'b0;
        word_rdy = 1'b1;
        rdm_num  = '0;
        expWordQ.delete();
        expLastQ.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Counts edges from the key request until the key and first word appear.
    task automatic wait_words(input int startEdge, output int lat);
        lat = -1;
        for (int e = startEdge; e < startEdge + 30; e++) begin
            if (word_vld && key_vld) begin
                lat = e;
                break;
            end
            tick();
        end
    endtask

    // Scoreboard drain: each handshake pops and compares one expected word.
    task automatic monitor_words(input string tag);
        logic [31:0] w;
        logic        l;
        int          n;
        n = 0;
        for (int i = 0; i < 60 && expWordQ.size() != 0; i++) begin
            if (word_vld && word_rdy) begin
                w = expWordQ.pop_front();
                l = expLastQ.pop_front();
                checkCount++;
                if (word_out !== w)
                    $display("[TB] FAIL %s_word%0d: got %h want %h", tag, n, word_out, w);
                else
                    passCount++;
                checkCount++;
                if (word_last !== l)
                    $display("[TB] FAIL %s_last%0d: got %0b want %0b", tag, n, word_last, l);
                else
                    passCount++;
                n++;
            end
            tick();
        end
        checkCount++;
        if (expWordQ.size() != 0) begin
            $display("[TB] FAIL %s_drain: %0d words still expected, want 0", tag, expWordQ.size());
            expWordQ.delete();
            expLastQ.delete();
        end else begin
            passCount++;
        end
        checkCount++;
        if ({busy, word_vld, key_vld} !== 3'b001)
            $display("[TB] FAIL %s_idle: busy/word_vld/key_vld got %b want 001", tag, {busy, word_vld, key_vld});
        else
            passCount++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        key_req  = 1'b0;
        err_clr  = 1'b0;
        word_rdy = 1'b1;
        rdm_num  = '0;
        tick();
        tick();
        checkCount++;
        if ({busy, err, key_vld, word_vld, word_last} !== 5'b0)
            $display("[TB] FAIL reset_flags: got %b want 00000", {busy, err, key_vld, word_vld, word_last});
        else
            passCount++;
        checkCount++;
        if ({key, word_out} !== 160'b0)
            $display("[TB] FAIL reset_data: key %h word %h want 0", key, word_out);
        else
            passCount++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        rdm_num  = keyOne;
        word_rdy = 1'b1;
        push_key(keyOne);
        pulse_req();
        wait_words(1, lat);
        checkCount++;
        if (lat !== 3)
            $display("[TB] FAIL basic_latency: got %0d want 3", lat);
        else
            passCount++;
        checkCount++;
        if (key !== keyOne)
            $display("[TB] FAIL basic_key: got %h want %h", key, keyOne);
        else
            passCount++;
        monitor_words("basic");
        checkCount++;
        if (key !== keyOne)
            $display("[TB] FAIL basic_key_held: got %h want %h", key, keyOne);
        else
            passCount++;
    endtask

    task automatic test_backpressure();
        int lat;
        apply_reset();
        rdm_num  = keyOne;
        word_rdy = 1'b0;
        push_key(keyOne);
        pulse_req();
        wait_words(1, lat);
        checkCount++;
        if (lat !== 3)
            $display("[TB] FAIL stall_latency: got %0d want 3", lat);
        else
            passCount++;
        for (int c = 0; c < 5; c++) begin
            checkCount++;
            if ({word_vld, word_last, word_out} !== {1'b1, 1'b0, 32'h01234567})
                $display("[TB] FAIL stall_hold%0d: vld %0b last %0b word %h want 1 0 01234567",
                         c, word_vld, word_last, word_out);
            else
                passCount++;
            tick();
        end
        word_rdy = 1'b1;
        monitor_words("stall");
    endtask

    task automatic test_retry_accept();
        int lat;
        rdm_num = '0;
        push_key(keyA5);
        pulse_req();
        tick();
        tick();
        tick();
        rdm_num = keyA5;
        wait_words(4, lat);
        checkCount++;
        if (lat !== 7)
            $display("[TB] FAIL retry_latency: got %0d want 7", lat);
        else
            passCount++;
        checkCount++;
        if (key !== keyA5)
            $display("[TB] FAIL retry_key: got %h want %h", key, keyA5);
        else
            passCount++;
        monitor_words("retry");
    endtask

    task automatic test_reject();
        int lat;
        // Candidate equal to the previous key must be refused once.
        rdm_num = keyA5;
        push_key(keyThree);
        pulse_req();
        tick();
        rdm_num = keyThree;
        wait_words(2, lat);
        checkCount++;
        if (lat !== 5)
            $display("[TB] FAIL rej_prev_latency: got %0d want 5", lat);
        else
            passCount++;
        monitor_words("rej_prev");
        // All-ones candidate must be refused once.
        rdm_num = '1;
        push_key(keyFour);
        pulse_req();
        tick();
        rdm_num = keyFour;
        wait_words(2, lat);
        checkCount++;
        if (lat !== 5)
            $display("[TB] FAIL rej_ones_latency: got %0d want 5", lat);
        else
            passCount++;
        monitor_words("rej_ones");
    endtask

    task automatic test_error();
        int lat;
        int errLat;
        rdm_num = '0;
        pulse_req();
        errLat = -1;
        for (int e = 1; e < 30; e++) begin
            if (err) begin
                errLat = e;
                break;
            end
            tick();
        end
        checkCount++;
        if (errLat !== 7)
            $display("[TB] FAIL err_latency: got %0d want 7", errLat);
        else
            passCount++;
        checkCount++;
        if ({err, busy, key_vld, word_vld} !== 4'b1000)
            $display("[TB] FAIL err_flags: err/busy/key_vld/word_vld got %b want 1000",
                     {err, busy, key_vld, word_vld});
        else
            passCount++;
        checkCount++;
        if (key !== keyFour)
            $display("[TB] FAIL err_key_held: got %h want %h", key, keyFour);
        else
            passCount++;
        pulse_req();
        tick();
        checkCount++;
        if ({err, busy} !== 2'b10)
            $display("[TB] FAIL err_ignore_req: err/busy got %b want 10", {err, busy});
        else
            passCount++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkCount++;
        if ({err, busy, key_vld} !== 3'b000)
            $display("[TB] FAIL err_clear: err/busy/key_vld got %b want 000", {err, busy, key_vld});
        else
            passCount++;
        // The previous key survives the error episode and is still refused.
        rdm_num = keyFour;
        push_key(keyThree);
        pulse_req();
        tick();
        rdm_num = keyThree;
        wait_words(2, lat);
        checkCount++;
        if (lat !== 5)
            $display("[TB] FAIL err_prev_latency: got %0d want 5", lat);
        else
            passCount++;
        monitor_words("after_err");
    endtask

    task automatic test_reset_mid_send();
        int lat;
        rdm_num  = keySix;
        word_rdy = 1'b1;
        pulse_req();
        wait_words(1, lat);
        tick();
        tick();
        checkCount++;
        if (word_out !== keySix[63:32])
            $display("[TB] FAIL midsend_word2: got %h want %h", word_out, keySix[63:32]);
        else
            passCount++;
        rst = 1'b1;
        #1;
        checkCount++;
        if ({busy, err, key_vld, word_vld, word_last} !== 5'b0)
            $display("[TB] FAIL midsend_async_flags: got %b want 00000",
                     {busy, err, key_vld, word_vld, word_last});
        else
            passCount++;
        checkCount++;
        if ({key, word_out} !== 160'b0)
            $display("[TB] FAIL midsend_async_data: key %h word %h want 0", key, word_out);
        else
            passCount++;
        tick();
        rst = 1'b0;
        push_key(keySix);
        pulse_req();
        wait_words(1, lat);
        checkCount++;
        if (lat !== 3)
            $display("[TB] FAIL fresh_latency: got %0d want 3", lat);
        else
            passCount++;
        monitor_words("fresh");
    endtask

    initial begin
        keyOne   = 128'h0123456789ABCDEF_FEDCBA9876543210;
        keyA5    = {16{8'hA5}};
        keyThree = 128'h11112222333344445555666677778888;
        keyFour  = 128'hDEADBEEF0BADF00DCAFEBABE12345678;
        keySix   = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_retry_accept();
        test_reject();
        test_error();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
